// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions: tx state encoding, frame constants, bit-period divisor
// Used by uart_tx_fifo and, later, by the matching receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_e;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned STOP_BITS = 1;

    // Clock cycles per bit, rounded to the nearest integer.
    function automatic int unsigned calc_div(input int unsigned clk_freq, input int unsigned baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock circular FIFO with registered full flag and occupancy count
// Ports:
//   clk_i        rising-edge clock
//   rst_ni       synchronous active-low reset (pointers and count cleared)
//   push_i       write request; ignored while full
//   push_data_i  write data
//   pop_i        read request; ignored while empty
//   pop_data_o   head entry (valid while !empty_o)
//   full_o       count == DEPTH (registered)
//   empty_o      count == 0
//   count_o      number of stored entries
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         pop_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             full_q, full_d;
    logic             push_ok, pop_ok;

    assign push_ok = push_i && !full_q;
    assign pop_ok  = pop_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + (AW+1)'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - (AW+1)'(1);
        end
        full_d = (count_d == (AW+1)'(DEPTH));
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign full_o     = full_q;
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - 8N1 UART transmitter fed by a small byte FIFO, back-to-back frames
// Ports:
//   sysclk      system clock, rising edge
//   reset       synchronous active-low reset; aborts any frame and flushes the FIFO
//   tx_data     byte to queue
//   tx_valid    write request, accepted when tx_ready is high
//   tx_ready    FIFO not full (forced low while reset is asserted)
//   UART_TX     serial line, idle high, straight from a flop
//   tx_busy     high while a frame (start, data, stop) is on the line
//   fifo_count  bytes waiting in the FIFO (excludes the byte being shifted out)
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100000000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                            sysclk,
    input  logic                            reset,
    input  logic [7:0]                      tx_data,
    input  logic                            tx_valid,
    output logic                            tx_ready,
    output logic                            UART_TX,
    output logic                            tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

    localparam int unsigned DIV   = calc_div(CLK_FREQ, BAUD);
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;

    logic             fifo_pop;
    logic [7:0]       fifo_data;
    logic             fifo_full;
    logic             fifo_empty;
    logic             bit_done;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (sysclk),
        .rst_ni      (reset),
        .push_i      (tx_valid),
        .push_data_i (tx_data),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign tx_ready = reset && !fifo_full;
    assign bit_done = (cnt_q == CNT_W'(DIV - 1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        fifo_pop  = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shreg_d  = fifo_data;
                    tx_d     = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = START;
                end
            end

            START: begin
                if (bit_done) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    tx_d      = shreg_q[0];
                    state_d   = DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DATA: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                        bit_idx_d = '0;
                        tx_d      = 1'b1;
                        state_d   = STOP;
                    end else begin
                        // Line shows shreg_q[0]; the next bit is shreg_q[1].
                        bit_idx_d = bit_idx_q + 3'd1;
                        shreg_d   = {1'b0, shreg_q[7:1]};
                        tx_d      = shreg_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            STOP: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (bit_idx_q != 3'(STOP_BITS - 1)) begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end else if (!fifo_empty) begin
                        // Chain the next frame with no idle gap.
                        fifo_pop  = 1'b1;
                        shreg_d   = fifo_data;
                        bit_idx_d = '0;
                        tx_d      = 1'b0;
                        state_d   = START;
                    end else begin
                        bit_idx_d = '0;
                        busy_d    = 1'b0;
                        state_d   = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign UART_TX = tx_q;
    assign tx_busy = busy_q;

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- 8N1 UART transmitter; the transmit counterpart of the board's UART receive path. Drives the top-level UART_TX pin.
- The CPU/MMIO side pushes bytes through a valid/ready write port into a small FIFO. The FIFO drains continuously onto the line, LSB first, with no idle gap between queued frames.
- Runs on sysclk (100 MHz board clock), default 9600 baud.

Parameters:
- CLK_FREQ, 100000000, sysclk frequency in Hz.
- BAUD, 9600, line rate in bit/s.
- FIFO_DEPTH, 4, queued bytes, excluding the byte in the shift register; must be a power of 2 and at least 2.

Ports:
- sysclk  in  1  system clock; all logic is rising-edge.
- reset  in  1  synchronous, active-low reset.
- tx_data  in  8  byte to send.
- tx_valid  in  1  write request.
- tx_ready  out  1  FIFO can accept a byte; equals !full; held 0 while reset=0.
- UART_TX  out  1  serial line, idle high; driven directly from a flop.
- tx_busy  out  1  high while a frame is on the line (states START, DATA, STOP).
- fifo_count  out  $clog2(FIFO_DEPTH)+1  bytes waiting in the FIFO.

Behaviour:
- Reset: all state is sampled on the sysclk edge while reset=0.
  - Reset values: UART_TX=1, tx_busy=0, fifo_count=0, FSM=IDLE, baud counter=0, FIFO pointers=0.
  - Reset mid-frame aborts the frame. The line is high from the next edge, and the FIFO is flushed.
- Bit period: DIV = (CLK_FREQ + BAUD/2) / BAUD, rounded to nearest (10417 at the defaults).
  - Every line level (start, 8 data, stop) is held exactly DIV cycles.
  - The baud counter runs only in non-IDLE states and restarts at 0 on every bit boundary.
- Write port:
  - A byte is accepted on an edge where tx_valid && tx_ready.
  - tx_ready is combinational from the registered full flag. A write while full is dropped, and the FIFO is unchanged.
  - A push and a pop on the same edge both take effect; fifo_count is unchanged.
- FSM:
  - IDLE: if FIFO is non-empty, pop into the shift register, set UART_TX=0, go to START. If an accept happens at edge E into an empty FIFO, UART_TX falls at edge E+1.
  - START: after DIV cycles, go to DATA with UART_TX=data[0] and bit index 0.
  - DATA: after each DIV cycles, shift. After bit 7 has been held DIV cycles, go to STOP with UART_TX=1.
  - STOP: after DIV cycles:
    - FIFO non-empty: pop, set UART_TX=0, go to START on the same edge (back-to-back frames).
    - Otherwise: go to IDLE.
- Frame length: exactly 10*DIV cycles from the start-bit falling edge to the end of the stop bit.
- tx_busy is registered and changes on the same edges as FSM state entry/exit.
- FIFO: circular buffer with wrapping read/write pointers. full means fifo_count==FIFO_DEPTH; empty means fifo_count==0.

Decomposition:
- Package uart_pkg:
  - tx state enum (IDLE, START, DATA, STOP).
  - Frame constants: DATA_BITS=8, STOP_BITS=1.
  - Function computing DIV from CLK_FREQ/BAUD. Shared with the receiver.
- Sub-module sync_fifo (parameterised WIDTH, DEPTH; push/pop/full/empty/count), reusable for a future RX buffer.
- The FSM, baud counter and shift register stay in uart_tx_fifo.
- Expected size is about 200 RTL lines total.

Test Plan:
- Single byte, defaults: write 0x54 while idle. UART_TX reads 0 (start), then 0,0,1,0,1,0,1,0, then 1 (stop). Each level lasts 10417 cycles. tx_busy drops after 104170 cycles. The falling edge is 1 cycle after the accept edge.
- Back-to-back: write 0x54 then 0x0C on consecutive cycles. The line shows two frames in 20 bit periods with no idle gap. The second frame's data is 0,0,1,1,0,0,0,0.
- Full FIFO (CLK_FREQ=16, BAUD=1, DIV=16): hold tx_valid for 6 cycles with data 1..6 from idle.
  - Exactly 5 bytes are accepted; the 6th is dropped with tx_ready=0.
  - fifo_count=4.
  - The line sends 1,2,3,4,5.
- Simultaneous push/pop: with the FIFO full, assert tx_valid on the stop-bit end edge. No accept happens that cycle. The pop frees a slot, tx_ready rises the next cycle, and the write is accepted then; fifo_count returns to 4.
- Reset mid-frame: pull reset low during data bit 3. UART_TX=1, tx_busy=0, fifo_count=0 on the next edge. After release, no frame is sent until a new write.
- Idle stability: with no writes for 10*DIV cycles after reset, UART_TX stays 1 and tx_ready stays 1.
